// File: rtl/i2c_master_tx.sv
// i2c_master_tx: write-only I2C master. Sends START, a 7-bit address with
// the write bit, then byte_cnt data bytes from an external FIFO, each followed
// by an ACK slot, and finishes with STOP. Every bit slot is four phases of QTR
// clocks. All outputs come straight from flops.
module i2c_master_tx #(
   parameter int unsigned QTR = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [6:0] slave_addr,
   input  logic [7:0] byte_cnt,
   input  logic       fifo_empty,
   output logic       fifo_rd_en,
   input  logic [7:0] fifo_dout,
   output logic       scl,
   output logic       sda_oe,
   input  logic       sda_in,
   output logic       busy,
   output logic       done,
   output logic       ack_err
);

   localparam int unsigned   QW       = (QTR > 1) ? $clog2(QTR) : 1;
   localparam logic [QW-1:0] QTR_LAST = QW'(QTR - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ADDR,
      S_ADDR_ACK,
      S_FETCH,
      S_DATA,
      S_DATA_ACK,
      S_STOP
   } state_t;

   // FETCH handshake: request the pop, let the FIFO update, capture the byte.
   typedef enum logic [1:0] {
      F_REQ,
      F_POP,
      F_CAP
   } fstep_t;

   state_t        state_q,   state_d;
   fstep_t        fstep_q,   fstep_d;
   logic [QW-1:0] qtr_q,     qtr_d;
   logic [1:0]    phase_q,   phase_d;
   logic [2:0]    bit_q,     bit_d;
   logic [7:0]    shift_q,   shift_d;
   logic [7:0]    rem_q,     rem_d;
   logic          nack_q,    nack_d;
   logic          ack_err_q, ack_err_d;
   logic          scl_q,     scl_d;
   logic          sda_oe_q,  sda_oe_d;
   logic          rd_en_q,   rd_en_d;
   logic          busy_q,    busy_d;
   logic          done_q,    done_d;

   logic qtr_last;
   logic slot_last;

   assign qtr_last  = (qtr_q == QTR_LAST);
   assign slot_last = qtr_last && (phase_q == 2'd3);

   // Next-state logic: slot timing, bit sequencing, ACK sampling, FIFO fetch.
   always_comb begin
      // NOTE: every _d gets its hold value first so no branch can infer a latch.
      state_d   = state_q;
      fstep_d   = fstep_q;
      qtr_d     = qtr_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      rem_d     = rem_q;
      nack_d    = nack_q;
      ack_err_d = ack_err_q;
      rd_en_d   = 1'b0;
      done_d    = 1'b0;

      // Slot timing runs in every bus state; FETCH freezes it with SCL low.
      if (state_q != S_IDLE && state_q != S_FETCH) begin
         if (qtr_last) begin
            qtr_d   = '0;
            phase_d = phase_q + 2'd1;
         end else begin
            qtr_d = qtr_q + QW'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_START;
               shift_d   = {slave_addr, 1'b0};
               rem_d     = byte_cnt;
               ack_err_d = 1'b0;
               nack_d    = 1'b0;
               qtr_d     = '0;
               phase_d   = 2'd0;
               bit_d     = 3'd0;
               fstep_d   = F_REQ;
            end
         end
         S_START: begin
            if (slot_last) state_d = S_ADDR;
         end
         S_ADDR, S_DATA: begin
            if (slot_last) begin
               if (bit_q == 3'd7) begin
                  bit_d   = 3'd0;
                  state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {shift_q[6:0], 1'b0};
               end
            end
         end
         S_ADDR_ACK, S_DATA_ACK: begin
            if (phase_q == 2'd3 && qtr_q == '0) nack_d = sda_in;
            if (slot_last) begin
               if (nack_q) begin
                  ack_err_d = 1'b1;
                  state_d   = S_STOP;
               end else if (rem_q == 8'd0) begin
                  state_d = S_STOP;
               end else begin
                  state_d = S_FETCH;
                  fstep_d = F_REQ;
               end
            end
         end
         S_FETCH: begin
            case (fstep_q)
               F_REQ: begin
                  if (!fifo_empty) begin
                     rd_en_d = 1'b1;
                     fstep_d = F_POP;
                  end
               end
               F_POP: fstep_d = F_CAP;
               default: begin
                  shift_d = fifo_dout;
                  rem_d   = rem_q - 8'd1;
                  bit_d   = 3'd0;
                  qtr_d   = '0;
                  phase_d = 2'd0;
                  fstep_d = F_REQ;
                  state_d = S_DATA;
               end
            endcase
         end
         S_STOP: begin
            if (slot_last) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bus levels for the upcoming cycle, derived from the next state and phase
   // so the registered pins line up with the state register.
   always_comb begin
      scl_d    = 1'b1;
      sda_oe_d = 1'b0;
      case (state_d)
         S_START: sda_oe_d = phase_d[1];
         S_ADDR, S_DATA: begin
            scl_d    = phase_d[1];
            sda_oe_d = ~shift_d[7];
         end
         S_ADDR_ACK, S_DATA_ACK: scl_d = phase_d[1];
         S_FETCH: begin
            scl_d    = 1'b0;
            sda_oe_d = sda_oe_q;
         end
         S_STOP: begin
            scl_d    = (phase_d != 2'd0);
            sda_oe_d = ~phase_d[1];
         end
         default: ;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset that releases the bus.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state_q   <= S_IDLE;
         fstep_q   <= F_REQ;
         qtr_q     <= '0;
         phase_q   <= 2'd0;
         bit_q     <= 3'd0;
         shift_q   <= 8'd0;
         rem_q     <= 8'd0;
         nack_q    <= 1'b0;
         ack_err_q <= 1'b0;
         scl_q     <= 1'b1;
         sda_oe_q  <= 1'b0;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         fstep_q   <= fstep_d;
         qtr_q     <= qtr_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         rem_q     <= rem_d;
         nack_q    <= nack_d;
         ack_err_q <= ack_err_d;
         scl_q     <= scl_d;
         sda_oe_q  <= sda_oe_d;
         rd_en_q   <= rd_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign scl        = scl_q;
   assign sda_oe     = sda_oe_q;
   assign fifo_rd_en = rd_en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
// tb_i2c_master_tx: bench for i2c_master_tx with a registered-output FIFO
// model, an I2C bus monitor that decodes START/STOP/bytes, and a slave that
// ACKs or NACKs on request.
module tb_i2c_master_tx;

   localparam int QTR  = 5;
   localparam int SLOT = 4 * QTR;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [6:0] slave_addr;
   logic [7:0] byte_cnt;
   logic       fifo_empty = 1'b1;
   logic       fifo_rd_en;
   logic [7:0] fifo_dout = 8'h00;
   logic       scl;
   logic       sda_oe;
   logic       sda_in = 1'b1;
   logic       busy;
   logic       done;
   logic       ack_err;

   int n_checks = 0;
   int n_fail   = 0;

   // FIFO model state: bench writes push_*, FIFO process owns rd_*.
   logic [7:0] push_mem [0:63];
   int         push_wr = 0;
   int         rd_idx  = 0;
   int         rd_cnt  = 0;
   int         rd_bad  = 0;

   // Bus monitor / slave state.
   logic [7:0] byte_log [0:255];
   int         byte_wr    = 0;
   int         frames     = 0;
   int         nbits      = 0;
   logic [7:0] sh         = 8'h00;
   logic       slave_pull = 1'b0;
   logic       prev_scl   = 1'b1;
   logic       prev_bus   = 1'b1;
   int         starts     = 0;
   int         stops      = 0;
   int         busy_cyc   = 0;
   int         done_cnt   = 0;
   bit         nack_addr  = 1'b0;
   bit         nack_data  = 1'b0;

   typedef struct {
      logic [6:0]      addr;
      logic [7:0]      cnt;
      int              ndata;
      logic [2:0][7:0] data;
      bit              nack_addr;
      bit              nack_data;
      bit              mid_start;
      int              exp_nbytes;
      logic [3:0][7:0] exp_bytes;
      bit              exp_err;
      int              exp_rd;
      int              exp_cycles;
   } vec_t;

   vec_t vecs [0:5];

   i2c_master_tx #(.QTR(QTR)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .slave_addr (slave_addr),
      .byte_cnt   (byte_cnt),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .scl        (scl),
      .sda_oe     (sda_oe),
      .sda_in     (sda_in),
      .busy       (busy),
      .done       (done),
      .ack_err    (ack_err)
   );

   always #5 clk = ~clk;

   // FIFO: data appears the cycle after the pop strobe.
   always @(negedge clk) begin
      if (fifo_rd_en === 1'b1) begin
         rd_cnt++;
         if (fifo_empty) rd_bad++;
         else begin
            fifo_dout = push_mem[rd_idx];
            rd_idx++;
         end
      end
      fifo_empty = (rd_idx == push_wr);
   end

   // Bus monitor and slave: wired-AND SDA, decode on SCL edges.
   always @(negedge clk) begin : mon
      logic bus;
      bus = !sda_oe && !slave_pull;
      if (scl === 1'b1 && prev_scl && prev_bus && !bus) begin
         starts++;
         nbits      = 0;
         frames     = 0;
         slave_pull = 1'b0;
      end else if (scl === 1'b1 && prev_scl && !prev_bus && bus) begin
         stops++;
         nbits = 0;
      end else if (scl === 1'b1 && !prev_scl) begin
         if (nbits < 8) begin
            sh = {sh[6:0], bus};
            nbits++;
            if (nbits == 8) begin
               byte_log[byte_wr[7:0]] = sh;
               byte_wr++;
               frames++;
            end
         end else begin
            nbits = 0;
         end
      end else if (scl === 1'b0 && prev_scl) begin
         if (nbits == 8) slave_pull = (frames == 1) ? !nack_addr : !nack_data;
         else            slave_pull = 1'b0;
      end
      sda_in   = !sda_oe && !slave_pull;
      prev_bus = sda_in;
      prev_scl = scl;
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) done_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      push_mem[push_wr] = b;
      push_wr++;
   endtask

   task automatic do_start(input string tag, input logic [6:0] a, input logic [7:0] n);
      @(negedge clk);
      slave_addr = a;
      byte_cnt   = n;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      slave_addr = 7'h00;
      byte_cnt   = 8'h00;
      check($sformatf("%s.busy_on_accept", tag), busy, 1);
      check($sformatf("%s.ack_err_cleared", tag), ack_err, 0);
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 4000 && !seen; i++) begin
         @(negedge clk);
         seen = (done === 1'b1);
      end
      check($sformatf("%s.done_seen", tag), seen, 1);
      repeat (5) @(negedge clk);
   endtask

   task automatic wait_scl(input string tag, input logic lvl);
      bit seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         seen = (scl === lvl);
      end
      check($sformatf("%s.scl_reached_%0d", tag, lvl), seen, 1);
   endtask

   task automatic wait_mon(input string tag, input int fr, input int nb);
      bit seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         seen = (frames == fr) && (nbits == nb);
      end
      check($sformatf("%s.monitor_reached_f%0d_b%0d", tag, fr, nb), seen, 1);
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int b0, rd0, dn0, st0, sp0, bc0;
      nack_addr = v.nack_addr;
      nack_data = v.nack_data;
      for (int j = 0; j < v.ndata; j++) push(v.data[j]);
      b0  = byte_wr;
      rd0 = rd_cnt;
      dn0 = done_cnt;
      st0 = starts;
      sp0 = stops;
      bc0 = busy_cyc;
      do_start(tag, v.addr, v.cnt);
      if (v.mid_start) begin
         repeat (40) @(negedge clk);
         slave_addr = 7'h33;
         byte_cnt   = 8'd5;
         start      = 1'b1;
         @(negedge clk);
         start      = 1'b0;
      end
      wait_done(tag);
      check($sformatf("%s.nbytes", tag), byte_wr - b0, v.exp_nbytes);
      for (int j = 0; j < v.exp_nbytes; j++)
         check($sformatf("%s.byte%0d", tag, j), byte_log[(b0 + j) % 256], v.exp_bytes[j]);
      check($sformatf("%s.ack_err", tag), ack_err, v.exp_err);
      check($sformatf("%s.busy_after", tag), busy, 0);
      check($sformatf("%s.fifo_reads", tag), rd_cnt - rd0, v.exp_rd);
      check($sformatf("%s.done_pulses", tag), done_cnt - dn0, 1);
      check($sformatf("%s.starts", tag), starts - st0, 1);
      check($sformatf("%s.stops", tag), stops - sp0, 1);
      check($sformatf("%s.busy_cycles", tag), busy_cyc - bc0, v.exp_cycles);
   endtask

   initial begin
      int b0, rd0, hi, rdp;
      rst_n      = 1'b0;
      start      = 1'b0;
      slave_addr = 7'h00;
      byte_cnt   = 8'h00;
      repeat (3) @(negedge clk);
      check("reset.scl", scl, 1);
      check("reset.sda_oe", sda_oe, 0);
      check("reset.busy", busy, 0);
      check("reset.done", done, 0);
      check("reset.ack_err", ack_err, 0);
      check("reset.fifo_rd_en", fifo_rd_en, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Slot count = 2 + 9*(N+1); each fetched byte adds 3 FIFO handshake cycles.
      vecs[0] = '{addr: 7'h50, cnt: 8'd2, ndata: 2, data: {8'h00, 8'h3C, 8'hA5},
                  nack_addr: 1'b0, nack_data: 1'b0, mid_start: 1'b0,
                  exp_nbytes: 3, exp_bytes: {8'h00, 8'h3C, 8'hA5, 8'hA0},
                  exp_err: 1'b0, exp_rd: 2, exp_cycles: 116 * QTR + 6};
      vecs[1] = '{addr: 7'h50, cnt: 8'd3, ndata: 0, data: 24'h0,
                  nack_addr: 1'b1, nack_data: 1'b0, mid_start: 1'b0,
                  exp_nbytes: 1, exp_bytes: {8'h00, 8'h00, 8'h00, 8'hA0},
                  exp_err: 1'b1, exp_rd: 0, exp_cycles: 11 * SLOT};
      vecs[2] = '{addr: 7'h7F, cnt: 8'd0, ndata: 0, data: 24'h0,
                  nack_addr: 1'b0, nack_data: 1'b0, mid_start: 1'b0,
                  exp_nbytes: 1, exp_bytes: {8'h00, 8'h00, 8'h00, 8'hFE},
                  exp_err: 1'b0, exp_rd: 0, exp_cycles: 11 * SLOT};
      vecs[3] = '{addr: 7'h2A, cnt: 8'd1, ndata: 1, data: {8'h00, 8'h00, 8'h81},
                  nack_addr: 1'b0, nack_data: 1'b1, mid_start: 1'b0,
                  exp_nbytes: 2, exp_bytes: {8'h00, 8'h00, 8'h81, 8'h54},
                  exp_err: 1'b1, exp_rd: 1, exp_cycles: 20 * SLOT + 3};
      vecs[4] = '{addr: 7'h01, cnt: 8'd1, ndata: 1, data: {8'h00, 8'h00, 8'hFF},
                  nack_addr: 1'b0, nack_data: 1'b0, mid_start: 1'b0,
                  exp_nbytes: 2, exp_bytes: {8'h00, 8'h00, 8'hFF, 8'h02},
                  exp_err: 1'b0, exp_rd: 1, exp_cycles: 20 * SLOT + 3};
      vecs[5] = '{addr: 7'h50, cnt: 8'd1, ndata: 1, data: {8'h00, 8'h00, 8'h11},
                  nack_addr: 1'b0, nack_data: 1'b0, mid_start: 1'b1,
                  exp_nbytes: 2, exp_bytes: {8'h00, 8'h00, 8'h11, 8'hA0},
                  exp_err: 1'b0, exp_rd: 1, exp_cycles: 20 * SLOT + 3};

      for (int i = 0; i < 6; i++) run_vec($sformatf("v%0d", i), vecs[i]);

      // Reset in the middle of the 4th data bit (0xA5 bit 4 is 0, SDA pulled).
      nack_addr = 1'b0;
      nack_data = 1'b0;
      push(8'hA5);
      do_start("rst", 7'h50, 8'd2);
      wait_mon("rst", 1, 3);
      wait_scl("rst", 1'b0);
      repeat (2 * QTR + 1) @(negedge clk);
      check("rst.pre_scl", scl, 1);
      check("rst.pre_sda_oe", sda_oe, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst.scl", scl, 1);
      check("rst.sda_oe", sda_oe, 0);
      check("rst.busy", busy, 0);
      check("rst.done", done, 0);
      check("rst.fifo_rd_en", fifo_rd_en, 0);
      check("rst.ack_err", ack_err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_vec("after_rst", vecs[0]);

      // FIFO runs dry after the first data byte: bus must stall with SCL low.
      b0  = byte_wr;
      rd0 = rd_cnt;
      push(8'hA5);
      do_start("stall", 7'h50, 8'd2);
      wait_mon("stall", 2, 8);
      wait_scl("stall", 1'b0);
      wait_scl("stall", 1'b1);
      wait_scl("stall", 1'b0);
      hi  = 0;
      rdp = 0;
      repeat (200) begin
         @(negedge clk);
         if (scl !== 1'b0) hi++;
         if (fifo_rd_en !== 1'b0) rdp++;
      end
      check("stall.scl_high_cycles", hi, 0);
      check("stall.rd_en_during_stall", rdp, 0);
      check("stall.busy", busy, 1);
      push(8'h3C);
      wait_done("stall");
      check("stall.nbytes", byte_wr - b0, 3);
      check("stall.byte0", byte_log[b0 % 256], 8'hA0);
      check("stall.byte1", byte_log[(b0 + 1) % 256], 8'hA5);
      check("stall.byte2", byte_log[(b0 + 2) % 256], 8'h3C);
      check("stall.fifo_reads", rd_cnt - rd0, 2);
      check("stall.ack_err", ack_err, 0);

      check("global.rd_en_while_empty", rd_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_master_tx.md
I2C_MASTER_TX -- requirements
Module: i2c_master_tx

Interface
REQ-001 SHALL have parameter QTR, default 5: system clocks per quarter SCL bit period (legal range >= 2).
REQ-002 SHALL have ports, in order:
  clk         in   1  single clock; all logic on posedge
  rst_n       in   1  synchronous, active-low reset
  start       in   1  one-cycle request to begin a write transaction
  slave_addr  in   7  target address, sampled when start is accepted
  byte_cnt    in   8  data bytes to send, sampled when start is accepted
  fifo_empty  in   1  byte FIFO empty flag
  fifo_rd_en  out  1  one-cycle pop strobe to byte FIFO
  fifo_dout   in   8  FIFO read data, valid the cycle after fifo_rd_en
  scl         out  1  SCL level driven by master
  sda_oe      out  1  1 = pull SDA low; 0 = release (bus reads high)
  sda_in      in   1  sampled SDA bus level
  busy        out  1  high from accepted start until done
  done        out  1  one-cycle pulse when STOP completes
  ack_err     out  1  sticky NACK flag for last transaction
REQ-003 One clock, clk; reset rst_n is synchronous and active-low.

Function
REQ-004 Every bit slot SHALL last 4 phases (0..3) of QTR clocks each; phase/quarter counters wrap 0..3 / 0..QTR-1.
REQ-005 Data/ACK slots: scl low in phases 0-1, high in 2-3; sda_oe updated only on entry to phase 0.
REQ-006 START slot: scl high all phases; sda_oe=0 in phases 0-1, 1 in phases 2-3.
REQ-007 STOP slot: scl low phase 0, high phases 1-3; sda_oe=1 in phases 0-1, 0 in phases 2-3.
REQ-008 FSM states SHALL be IDLE, START, ADDR, ADDR_ACK, FETCH, DATA, DATA_ACK, STOP.
REQ-009 IDLE: scl=1, sda_oe=0, busy=0; start=1 SHALL latch slave_addr/byte_cnt, clear ack_err, set busy, go START next cycle.
REQ-010 start while busy=1 SHALL be ignored with no effect on state or latched values.
REQ-011 ADDR: shift {slave_addr,1'b0} MSB first, 8 slots; sda_oe = ~bit.
REQ-012 ADDR_ACK/DATA_ACK: sda_oe=0; sda_in sampled on first clock of phase 3; 0 = ACK, 1 = NACK.
REQ-013 NACK SHALL set ack_err=1 and go to STOP; no further fifo_rd_en in that transaction.
REQ-014 After ACK: if remaining count is 0 go STOP, else go FETCH.
REQ-015 FETCH: scl held low, sda_oe holds its last value; when fifo_empty=0 assert fifo_rd_en for exactly one cycle, capture fifo_dout next cycle, decrement remaining count, enter DATA at phase 0.
REQ-016 FETCH with fifo_empty=1 SHALL wait indefinitely with scl low (bus stall), no timeout.
REQ-017 DATA: shift captured byte MSB first, 8 slots, then DATA_ACK.
REQ-018 byte_cnt=0 SHALL produce START, address, ACK slot, STOP, with zero FIFO reads.
REQ-019 End of STOP: done=1 for one cycle, busy=0 the same cycle, return to IDLE; ack_err holds until the next accepted start.
REQ-020 fifo_rd_en SHALL never assert outside FETCH or when fifo_empty=1.
REQ-021 Transaction of N bytes with all ACKs SHALL last (2+9*(N+1))*4*QTR clocks plus FETCH stall/fetch cycles.

Reset
REQ-022 rst_n=0 at any posedge, including mid-transaction, SHALL force IDLE next cycle: scl=1, sda_oe=0, fifo_rd_en=0, busy=0, done=0, ack_err=0, counters and shift register cleared.
REQ-023 No STOP is generated on reset; the bus is released immediately.
REQ-024 Outputs SHALL be fully registered; no combinational path from sda_in or fifo_empty to any output.

Verification
REQ-025 addr 0x50, byte_cnt 2, FIFO {0xA5,0x3C}, slave ACKs -> serial bytes 0xA0,0xA5,0x3C; exactly 2 fifo_rd_en pulses; done once; ack_err=0; duration 116*QTR clocks plus fetch cycles.
REQ-026 addr 0x50, byte_cnt 3, slave NACKs address -> ack_err=1, zero fifo_rd_en, STOP follows ADDR_ACK, done pulses.
REQ-027 byte_cnt 2, FIFO empty after byte 1 for 200 clocks -> scl held low throughout stall; second byte sent correctly once FIFO refilled.
REQ-028 rst_n low during 4th data bit -> next cycle scl=1, sda_oe=0, busy=0; subsequent start runs a clean transaction.
REQ-029 start pulsed again mid-transaction with different addr -> ignored; serial address unchanged; single done.
REQ-030 byte_cnt 0, addr 0x7F, ACK -> address byte 0xFE on SDA, no FIFO reads, done once.
